// File: rtl/mandel_pkg.sv
// Shared constants, types and FSM encoding for the Mandelbrot host feeder.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mandel_pkg;

  localparam int COORD_W = 14;
  localparam int ITER_W  = 7;

  // Signed Q2.12 coordinate, bits [13:12] integer part.
  typedef logic signed [COORD_W-1:0] coord_t;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD_X = 3'd1,
    LOAD_Y = 3'd2,
    SETTLE = 3'd3,
    RUN    = 3'd4,
    RESULT = 3'd5
  } state_t;

  localparam int                WDOG_W     = 10;
  localparam logic [WDOG_W-1:0] WDOG_LIMIT = 10'd1023;

endpackage

// File: rtl/mandel_watchdog.sv
// Watchdog counter for a pixel that never finishes; counts enabled cycles.
// Latency: expired is combinational from the count, count updates next edge.
// Backpressure: none; clr wins over en.
module mandel_watchdog
  import mandel_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  logic [WDOG_W-1:0] count_q;

  // Clear before the run starts, then count every enabled cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (clr) begin
      count_q <= '0;
    end else if (en) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign expired = en && (count_q == WDOG_LIMIT);

endmodule

// File: rtl/mandel_feeder.sv
// Loads one pixel (x then y) into the Mandelbrot core and returns its result.
// Latency: load strobes 1 and 2 cycles after accept; result 1 cycle after done.
// Backpressure: req_ready only in IDLE; result held until res_ready.
// Option: MANDEL_FEEDER_TIMEOUT_EN adds a run watchdog driving res_timeout.
module mandel_feeder #(
  parameter int COORD_W = mandel_pkg::COORD_W,
  parameter int ITER_W  = mandel_pkg::ITER_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [COORD_W-1:0] req_cr,
  input  logic [COORD_W-1:0] req_ci,
  input  logic [ITER_W-1:0]  req_max_iter,
  output logic [COORD_W-1:0] core_value,
  output logic               core_load_x,
  output logic               core_load_en,
  input  logic               core_escaped,
  input  logic [ITER_W-1:0]  core_iter,
  output logic               res_valid,
  input  logic               res_ready,
  output logic               res_escaped,
  output logic [ITER_W-1:0]  res_iter,
  output logic               res_timeout
);

  import mandel_pkg::*;

  state_t             state_q, state_d;
  logic [COORD_W-1:0] value_q;
  logic [COORD_W-1:0] ci_q;
  logic [ITER_W-1:0]  max_q;
  logic               esc_q;
  logic [ITER_W-1:0]  iter_q;
  logic               accept;
  logic               done;
  logic               finish;

  assign accept = (state_q == IDLE) && req_valid;
  // Escape and limit both count as done; the escaped flag is taken as-is.
  assign done   = core_escaped || (core_iter == max_q);

`ifdef MANDEL_FEEDER_TIMEOUT_EN
  logic wd_expired;
  logic timeout_q;

  mandel_watchdog u_watchdog (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (state_q == SETTLE),
    .en      (state_q == RUN),
    .expired (wd_expired)
  );

  assign finish = done || wd_expired;

  // Timeout flag only when the watchdog fires without a real completion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timeout_q <= 1'b0;
    end else if ((state_q == RUN) && finish) begin
      timeout_q <= !done;
    end
  end

  assign res_timeout = timeout_q;
`else
  assign finish      = done;
  assign res_timeout = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: fixed load sequence, then wait for completion and handshake.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req_valid) state_d = LOAD_X;
      LOAD_X:  state_d = LOAD_Y;
      LOAD_Y:  state_d = SETTLE;
      SETTLE:  state_d = RUN;
      RUN:     if (finish) state_d = RESULT;
      RESULT:  if (res_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Capture the request, steer the value bus, and latch the core's result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value_q <= '0;
      ci_q    <= '0;
      max_q   <= '0;
      esc_q   <= 1'b0;
      iter_q  <= '0;
    end else begin
      if (accept) begin
        value_q <= req_cr;
        ci_q    <= req_ci;
        max_q   <= req_max_iter;
      end
      if (state_q == LOAD_X) begin
        value_q <= ci_q;
      end
      if ((state_q == RUN) && finish) begin
        esc_q  <= core_escaped;
        iter_q <= core_iter;
      end
    end
  end

  // Ready is withheld while reset is held so nothing is accepted mid-reset.
  assign req_ready    = rst_n && (state_q == IDLE);
  assign core_value   = value_q;
  assign core_load_x  = (state_q == LOAD_X);
  assign core_load_en = (state_q == LOAD_X) || (state_q == LOAD_Y);
  assign res_valid    = (state_q == RESULT);
  assign res_escaped  = esc_q;
  assign res_iter     = iter_q;

endmodule

// File: tb/tb_mandel_feeder.sv
// Directed bench for mandel_feeder with a tiny behavioural core model.
// Latency: checks exact load and result cycles against hand-worked numbers.
// Backpressure: exercises held results and req_ready gating.
module tb_mandel_feeder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [13:0] req_cr;
  logic [13:0] req_ci;
  logic [6:0]  req_max_iter;
  logic [13:0] core_value;
  logic        core_load_x;
  logic        core_load_en;
  logic        core_escaped;
  logic [6:0]  core_iter;
  logic        res_valid;
  logic        res_ready;
  logic        res_escaped;
  logic [6:0]  res_iter;
  logic        res_timeout;

  int checks   = 0;
  int failures = 0;

  // Core model controls: escape iteration (0 = never) and iteration ceiling.
  int   esc_at = 0;
  int   cap    = 127;
  int   phase  = 0;
  logic y_edge;

  always #5 clk = ~clk;

  mandel_feeder dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_cr       (req_cr),
    .req_ci       (req_ci),
    .req_max_iter (req_max_iter),
    .core_value   (core_value),
    .core_load_x  (core_load_x),
    .core_load_en (core_load_en),
    .core_escaped (core_escaped),
    .core_iter    (core_iter),
    .res_valid    (res_valid),
    .res_ready    (res_ready),
    .res_escaped  (res_escaped),
    .res_iter     (res_iter),
    .res_timeout  (res_timeout)
  );

  // Core model: restarts on the y load; iter is 0 in SETTLE and first RUN
  // cycle, then counts up to cap; escaped latches when iter hits esc_at.
  always @(posedge clk) begin
    y_edge = core_load_en && !core_load_x;
    #1;
    if (y_edge) begin
      phase        = 0;
      core_iter    = '0;
      core_escaped = 1'b0;
    end else begin
      phase = phase + 1;
      if (phase >= 2 && !core_escaped && int'(core_iter) < cap)
        core_iter = core_iter + 7'd1;
      core_escaped = (esc_at != 0) && (int'(core_iter) == esc_at);
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Present a request and check the three load-phase cycles; returns in SETTLE.
  task automatic send_req(input logic [13:0] cr, input logic [13:0] ci, input logic [6:0] mi);
    @(negedge clk);
    chk("req_ready_idle", 32'(req_ready), 32'd1);
    req_valid    = 1'b1;
    req_cr       = cr;
    req_ci       = ci;
    req_max_iter = mi;
    @(negedge clk);
    req_valid = 1'b0;
    req_cr    = '0;
    req_ci    = '0;
    chk("loadx_value", 32'(core_value), 32'(cr));
    chk("loadx_flags", {30'd0, core_load_x, core_load_en}, 32'd3);
    chk("loadx_ready", 32'(req_ready), 32'd0);
    @(negedge clk);
    chk("loady_value", 32'(core_value), 32'(ci));
    chk("loady_flags", {30'd0, core_load_x, core_load_en}, 32'd1);
    @(negedge clk);
    chk("settle_en", 32'(core_load_en), 32'd0);
    chk("settle_value_hold", 32'(core_value), 32'(ci));
  endtask

  // Wait for res_valid, returning the cycle count from SETTLE (0 on timeout).
  task automatic wait_result(input int bound, output int lat);
    lat = 0;
    for (int i = 1; i <= bound; i++) begin
      @(negedge clk);
      if (res_valid) begin
        lat = i;
        break;
      end
    end
  endtask

  initial begin
    int lat;
    logic [6:0] held_iter;
    rst_n        = 1'b0;
    req_valid    = 1'b0;
    req_cr       = '0;
    req_ci       = '0;
    req_max_iter = '0;
    res_ready    = 1'b0;
    core_escaped = 1'b0;
    core_iter    = '0;

    #12;
    chk("rst_value", 32'(core_value), 32'd0);
    chk("rst_flags", {28'd0, core_load_x, core_load_en, res_valid, req_ready}, 32'd0);
    chk("rst_res", {23'd0, res_escaped, res_iter, res_timeout}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_release_ready", 32'(req_ready), 32'd1);

    // Escape at iteration 12; consumer already ready.
    esc_at    = 12;
    cap       = 127;
    res_ready = 1'b1;
    send_req(14'h3000, 14'h0400, 7'd100);
    wait_result(100, lat);
    chk("esc_latency", 32'(lat), 32'd14);
    chk("esc_result", {24'd0, res_escaped, res_iter}, {24'd0, 1'b1, 7'd12});
    chk("esc_timeout", 32'(res_timeout), 32'd0);
    @(negedge clk);
    chk("esc_back_idle", {30'd0, res_valid, req_ready}, 32'd1);

    // Limit of 20, never escapes; consumer stalls for 5 cycles.
    esc_at    = 0;
    res_ready = 1'b0;
    send_req(14'h0FFF, 14'h2001, 7'd20);
    wait_result(100, lat);
    chk("lim_latency", 32'(lat), 32'd22);
    chk("lim_result", {24'd0, res_escaped, res_iter}, {24'd0, 1'b0, 7'd20});
    held_iter = 7'd20;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_state", {22'd0, res_valid, req_ready, res_escaped, res_iter},
          {22'd0, 1'b1, 1'b0, 1'b0, held_iter});
    end
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    chk("hold_release", {30'd0, res_valid, req_ready}, 32'd1);

    // Zero limit: done on the very first RUN cycle.
    send_req(14'h0001, 14'h3FFF, 7'd0);
    @(negedge clk);
    chk("zero_run_cycle", 32'(res_valid), 32'd0);
    @(negedge clk);
    chk("zero_result", {23'd0, res_valid, res_escaped, res_iter}, {23'd0, 1'b1, 1'b0, 7'd0});
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;

    // Reset in the middle of RUN clears everything immediately.
    send_req(14'h1555, 14'h0AAA, 7'd100);
    repeat (5) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_flags", {28'd0, core_load_x, core_load_en, res_valid, req_ready}, 32'd0);
    chk("midrst_value", 32'(core_value), 32'd0);
    chk("midrst_res", {23'd0, res_escaped, res_iter, res_timeout}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Normal request after reset.
    res_ready = 1'b1;
    send_req(14'h1234, 14'h0ABC, 7'd3);
    wait_result(100, lat);
    chk("post_rst_latency", 32'(lat), 32'd5);
    chk("post_rst_result", {24'd0, res_escaped, res_iter}, {24'd0, 1'b0, 7'd3});
    @(negedge clk);
    res_ready = 1'b0;

    // Core stuck at iteration 5 with a limit it never reaches.
    cap = 5;
    send_req(14'h2000, 14'h0100, 7'd100);
`ifdef MANDEL_FEEDER_TIMEOUT_EN
    wait_result(1200, lat);
    chk("wdog_fired", 32'(lat != 0), 32'd1);
    chk("wdog_result", {23'd0, res_timeout, res_escaped, res_iter}, {23'd0, 1'b1, 1'b0, 7'd5});
`else
    wait_result(1100, lat);
    chk("stuck_no_result", 32'(lat), 32'd0);
    chk("stuck_timeout", 32'(res_timeout), 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mandel_feeder.md
# mandel_feeder

Host-side initiator for the Mandelbrot core's coordinate-load interface. It accepts one pixel request (cr, ci, iteration limit) on a valid/ready port and drives the core's 14-bit value bus with the two load strobes, x first, then y. It then watches the core's escaped flag and iteration count until the pixel completes, and returns the result on a second valid/ready port. It sits between the pixel scheduler and the Mandelbrot core pins (value/input_x/input_en in, escaped/iter out).

## Interface
Parameters:
- COORD_W, 14: coordinate width, signed fixed point Q2.12, bits [13:12] integer.
- ITER_W, 7: iteration count width.

Ports:
- clk  in  1  clock; single clock domain.
- rst_n  in  1  reset, asynchronous, active-low.
- req_valid  in  1  pixel request valid.
- req_ready  out  1  feeder can accept a request.
- req_cr  in  COORD_W  real coordinate.
- req_ci  in  COORD_W  imaginary coordinate.
- req_max_iter  in  ITER_W  iteration limit.
- core_value  out  COORD_W  value bus to core.
- core_load_x  out  1  1 = value is x, 0 = value is y.
- core_load_en  out  1  load strobe.
- core_escaped  in  1  core escaped flag.
- core_iter  in  ITER_W  core iteration count.
- res_valid  out  1  result valid.
- res_ready  in  1  result consumer ready.
- res_escaped  out  1  pixel escaped.
- res_iter  out  ITER_W  final iteration count.
- res_timeout  out  1  watchdog abort flag.

## Operation
- FSM states: IDLE, LOAD_X, LOAD_Y, SETTLE, RUN, RESULT.
- IDLE: req_ready=1. On req_valid, capture cr, ci and max_iter, then go to LOAD_X.
- LOAD_X: core_value=cr, core_load_x=1, core_load_en=1. Go to LOAD_Y.
- LOAD_Y: core_value=ci, core_load_x=0, core_load_en=1. Go to SETTLE.
- SETTLE: core_load_en=0. One cycle for the core to start. Go to RUN.
- RUN: sample the core each cycle. Done when core_escaped=1 or core_iter==max_iter. On done, register res_escaped=core_escaped and res_iter=core_iter, then go to RESULT.
- RESULT: res_valid=1; outputs held stable until res_ready. On the handshake, go to IDLE.
- Outside LOAD_X/LOAD_Y: core_load_en=0, and core_value holds its last driven value.
- max_iter=0: done on the first RUN cycle.
- Simultaneous escape and limit: res_escaped=1.
- No request overlap: req_ready=0 in every state except IDLE.
- Requests are arithmetic-free pass-through; the block does no saturation or sign adjustment.

## Timing
- Reset (async, rst_n low): state=IDLE, core_value=0, core_load_x=0, core_load_en=0, res_valid=0, res_escaped=0, res_iter=0, res_timeout=0. req_ready=1 once rst_n is high.
- Request accepted at edge T: LOAD_X during T..T+1, LOAD_Y during T+1..T+2, SETTLE during T+2..T+3, first RUN sample at T+3..T+4.
- Result latency: done detected in cycle N sets res_valid=1 in cycle N+1.
- res_ready high in the first RESULT cycle: handshake completes that cycle, IDLE next cycle, req_ready high next cycle. Minimum request-to-request spacing is 6 cycles.
- rst_n asserted mid-operation: core_load_en drops immediately and any pending result is discarded.
- req_valid may drop without acceptance; nothing is captured outside IDLE.

## Configuration
- MANDEL_FEEDER_TIMEOUT_EN defined:
  - A 10-bit watchdog clears on entry to RUN and increments each RUN cycle.
  - At count 1023 without done, go to RESULT with res_timeout=1, res_escaped=0, res_iter=core_iter sampled that cycle.
  - A normal done in the same cycle takes priority, with res_timeout=0.
- Not defined: no watchdog, and res_timeout is tied 0. The port is present in both builds.

## Structure
- Shared package mandel_pkg:
  - COORD_W and ITER_W constants.
  - Signed coordinate typedef.
  - FSM state enum.
  - Watchdog limit constant 1023.
- Sub-module mandel_watchdog: the timeout counter with clear/enable/expired. Instantiated only under MANDEL_FEEDER_TIMEOUT_EN.

## Test plan
- Reset, then a request with cr=0x3000 (-1.0), ci=0x0400 (0.25), max_iter=100: LOAD_X drives 0x3000 with load_x=1, next cycle 0x0400 with load_x=0. Model core escapes at iter 12 → res_escaped=1, res_iter=12, res_valid one cycle after the escape.
- max_iter=20, core never escapes → result at core_iter=20, res_escaped=0.
- max_iter=0 → res_valid rises at T+4 with res_iter=0.
- Hold res_ready=0 for 5 cycles: result stable and req_ready=0 throughout. Pulse res_ready → IDLE and req_ready=1 the next cycle.
- Assert rst_n low during RUN → all outputs 0 immediately. The next request proceeds normally.
- With MANDEL_FEEDER_TIMEOUT_EN, core iter stuck at 5 with max_iter=100 → res_timeout=1, res_iter=5 after 1023 RUN cycles. Without the macro → no result, res_timeout=0.
